// File: rtl/isp_multi_line_buffer.sv
// Circular multi-line buffer: keeps the last LINES-1 image lines in per-line RAM banks
// and emits a vertical column of LINES pixels one cycle after each accepted pixel.

module isp_mlb_ram #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Non-blocking write and read in one block give read-first behaviour on collision.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

module isp_multi_line_buffer #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 11,
  parameter int LINES      = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        frame_start_i,
  input  logic [ADDR_WIDTH-1:0]       line_width_i,
  input  logic                        pixel_valid_i,
  input  logic [DATA_WIDTH-1:0]       pixel_data_i,
  output logic                        col_valid_o,
  output logic [LINES*DATA_WIDTH-1:0] col_data_o,
  output logic [ADDR_WIDTH-1:0]       col_x_o,
  output logic                        col_last_o,
  output logic [2:0]                  rows_filled_o
);

  localparam int         NB       = LINES - 1;
  localparam int         BW       = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [2:0] ROWS_MAX = 3'(NB);

  function automatic logic [2:0] sat_inc(input logic [2:0] r);
    return (r >= ROWS_MAX) ? ROWS_MAX : r + 3'd1;
  endfunction

  function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
    return (b == BW'(NB - 1)) ? '0 : b + BW'(1);
  endfunction

  logic [ADDR_WIDTH-1:0] x_q, x_d, x_eff;
  logic [ADDR_WIDTH-1:0] width_q, width_d, width_eff;
  logic [BW-1:0]         bank_q, bank_d, bank_eff;
  logic [2:0]            rows_q, rows_d, rows_eff;
  logic                  wrap;
  logic                  acc_p0;

  // Stage p0: position / bank / fill state, with frame_start overriding the stored values.
  always_comb begin
    x_eff     = frame_start_i ? '0 : x_q;
    bank_eff  = frame_start_i ? '0 : bank_q;
    rows_eff  = frame_start_i ? '0 : rows_q;
    width_eff = frame_start_i ? line_width_i : width_q;
    wrap      = (x_eff == (width_eff - ADDR_WIDTH'(1)));
    acc_p0    = pixel_valid_i && !rst_i;
    x_d       = x_eff;
    bank_d    = bank_eff;
    rows_d    = rows_eff;
    width_d   = width_eff;
    if (pixel_valid_i) begin
      if (wrap) begin
        x_d    = '0;
        bank_d = bank_inc(bank_eff);
        rows_d = sat_inc(rows_eff);
      end else begin
        x_d = x_eff + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q     <= '0;
      bank_q  <= '0;
      rows_q  <= '0;
      width_q <= '0;
    end else begin
      x_q     <= x_d;
      bank_q  <= bank_d;
      rows_q  <= rows_d;
      width_q <= width_d;
    end
  end

  logic [DATA_WIDTH-1:0] rd_data [NB];

  for (genvar g = 0; g < NB; g++) begin : g_bank
    isp_mlb_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
      .clk_i   (clk_i),
      .we_i    (acc_p0 && (bank_eff == BW'(g))),
      .waddr_i (x_eff),
      .wdata_i (pixel_data_i),
      .re_i    (acc_p0),
      .raddr_i (x_eff),
      .rdata_o (rd_data[g])
    );
  end

  logic                  vld_p1_q;
  logic [DATA_WIDTH-1:0] pix_p1_q;
  logic [ADDR_WIDTH-1:0] x_p1_q;
  logic                  last_p1_q;
  logic [2:0]            rows_p1_q;
  logic [BW-1:0]         bsel_p1_q;

  // Stage p1: capture per-column context alongside the RAM read; held through input gaps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1_q  <= 1'b0;
      pix_p1_q  <= '0;
      x_p1_q    <= '0;
      last_p1_q <= 1'b0;
      rows_p1_q <= '0;
      bsel_p1_q <= '0;
    end else begin
      vld_p1_q <= pixel_valid_i;
      if (pixel_valid_i) begin
        pix_p1_q  <= pixel_data_i;
        x_p1_q    <= x_eff;
        last_p1_q <= wrap;
        rows_p1_q <= rows_eff;
        bsel_p1_q <= bank_eff;
      end
    end
  end

  // Slice k comes from bank (b-k) mod NB; slices beyond the fill level are forced to 0,
  // which also hides stale RAM contents after reset or a frame restart.
  always_comb begin
    int idx;
    idx        = 0;
    col_data_o = '0;
    col_data_o[0 +: DATA_WIDTH] = pix_p1_q;
    for (int k = 1; k <= NB; k++) begin
      idx = int'(bsel_p1_q) + NB - k;
      if (idx >= NB) idx = idx - NB;
      if (3'(k) <= rows_p1_q) col_data_o[k*DATA_WIDTH +: DATA_WIDTH] = rd_data[idx];
    end
  end

  assign col_valid_o   = vld_p1_q;
  assign col_x_o       = x_p1_q;
  assign col_last_o    = last_p1_q;
  assign rows_filled_o = rows_p1_q;

endmodule

// File: tb/tb_isp_multi_line_buffer.sv
// Directed bench for isp_multi_line_buffer: a LINES=3 wide instance and an ADDR_WIDTH=3 instance.

module tb_isp_multi_line_buffer;

  localparam int DW = 14;
  localparam int AW = 11;
  localparam int L  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          fs = 1'b0;
  logic          pv = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [AW-1:0] lw_a = '0;
  logic [2:0]    lw_b = '0;

  logic          a_vld, a_last;
  logic [L*DW-1:0] a_data;
  logic [AW-1:0] a_x;
  logic [2:0]    a_rows;

  logic          b_vld, b_last;
  logic [L*DW-1:0] b_data;
  logic [2:0]    b_x;
  logic [2:0]    b_rows;

  isp_multi_line_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINES(L)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .frame_start_i(fs), .line_width_i(lw_a),
    .pixel_valid_i(pv), .pixel_data_i(pd), .col_valid_o(a_vld), .col_data_o(a_data),
    .col_x_o(a_x), .col_last_o(a_last), .rows_filled_o(a_rows)
  );

  isp_multi_line_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .LINES(L)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .frame_start_i(fs), .line_width_i(lw_b),
    .pixel_valid_i(pv), .pixel_data_i(pd), .col_valid_o(b_vld), .col_data_o(b_data),
    .col_x_o(b_x), .col_last_o(b_last), .rows_filled_o(b_rows)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] col3(input int s0, input int s1, input int s2);
    logic [L*DW-1:0] c;
    c = {14'(s2), 14'(s1), 14'(s0)};
    return 64'(c);
  endfunction

  task automatic step(input logic r, input logic f, input logic v, input int d);
    rst = r; fs = f; pv = v; pd = 14'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int s0, input int s1, input int s2,
                       input int x, input int last, input int rows);
    chk({tag, ".vld"},  64'(a_vld),  64'(1));
    chk({tag, ".data"}, 64'(a_data), col3(s0, s1, s2));
    chk({tag, ".x"},    64'(a_x),    64'(x));
    chk({tag, ".last"}, 64'(a_last), 64'(last));
    chk({tag, ".rows"}, 64'(a_rows), 64'(rows));
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, ".vld"},  64'(a_vld),  64'(0));
    chk({tag, ".data"}, 64'(a_data), 64'(0));
    chk({tag, ".x"},    64'(a_x),    64'(0));
    chk({tag, ".last"}, 64'(a_last), 64'(0));
    chk({tag, ".rows"}, 64'(a_rows), 64'(0));
  endtask

  // Width-4 stream of pixels 1..4*nlines; the column above pixel p is p-4, p-8.
  task automatic run_lines(input string tag, input int nlines, input bit gapped);
    int ln, c, s1, s2, rows;
    for (int p = 1; p <= 4 * nlines; p++) begin
      ln   = (p - 1) / 4;
      c    = (p - 1) % 4;
      s1   = (ln >= 1) ? p - 4 : 0;
      s2   = (ln >= 2) ? p - 8 : 0;
      rows = (ln > 2) ? 2 : ln;
      step(1'b0, 1'b0, 1'b1, p);
      chk_a($sformatf("%s.p%0d", tag, p), p, s1, s2, c, (c == 3) ? 1 : 0, rows);
      if (gapped) begin
        step(1'b0, 1'b0, 1'b0, 0);
        chk($sformatf("%s.gap%0d.vld", tag, p), 64'(a_vld), 64'(0));
        chk($sformatf("%s.gap%0d.data", tag, p), 64'(a_data), col3(p, s1, s2));
      end
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 0);
    chk_a_zero("reset");
    chk("reset.b_vld", 64'(b_vld), 64'(0));

    // width=0 on the 3-bit-address instance wraps after 8 pixels
    lw_b = 3'd0;
    lw_a = 11'd4;
    step(1'b0, 1'b1, 1'b0, 0);
    for (int p = 1; p <= 9; p++) begin
      step(1'b0, 1'b0, 1'b1, p);
      if (p <= 8) begin
        chk($sformatf("w0.p%0d.data", p), 64'(b_data), col3(p, 0, 0));
        chk($sformatf("w0.p%0d.x", p),    64'(b_x),    64'(p - 1));
        chk($sformatf("w0.p%0d.last", p), 64'(b_last), 64'((p == 8) ? 1 : 0));
      end else begin
        chk("w0.p9.data", 64'(b_data), col3(9, 1, 0));
        chk("w0.p9.x",    64'(b_x),    64'(0));
        chk("w0.p9.rows", 64'(b_rows), 64'(1));
      end
    end

    // continuous 5 lines, width 4, covering bank rotation past fill
    step(1'b0, 1'b1, 1'b0, 0);
    chk("fs_idle.vld", 64'(a_vld), 64'(0));
    run_lines("cont", 5, 1'b0);
    chk("cont.last_line_tail", 64'(a_data), col3(20, 16, 12));

    // same three lines with a gap after each pixel
    step(1'b0, 1'b1, 1'b0, 0);
    run_lines("gap", 3, 1'b1);

    // frame restart mid-line with coincident pixel and a new width of 2
    step(1'b0, 1'b1, 1'b0, 0);
    for (int p = 1; p <= 6; p++) step(1'b0, 1'b0, 1'b1, p);
    chk_a("pre_fs", 6, 2, 0, 1, 0, 1);
    lw_a = 11'd2;
    step(1'b0, 1'b1, 1'b1, 100);
    chk_a("fs.p0", 100, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 101);
    chk_a("fs.p1", 101, 0, 0, 1, 1, 0);
    step(1'b0, 1'b0, 1'b1, 102);
    chk_a("fs.p2", 102, 100, 0, 0, 0, 1);

    // reset during line 1, then restart; stale RAM must stay masked
    lw_a = 11'd4;
    step(1'b0, 1'b1, 1'b0, 0);
    for (int p = 1; p <= 6; p++) step(1'b0, 1'b0, 1'b1, p);
    step(1'b1, 1'b0, 1'b1, 7);
    chk_a_zero("rst_mid");
    step(1'b0, 1'b1, 1'b1, 50);
    chk_a("rst.p0", 50, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 51);
    step(1'b0, 1'b0, 1'b1, 52);
    step(1'b0, 1'b0, 1'b1, 53);
    chk_a("rst.p3", 53, 0, 0, 3, 1, 0);
    step(1'b0, 1'b0, 1'b1, 54);
    chk_a("rst.p4", 54, 50, 0, 0, 0, 1);
    step(1'b0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/isp_multi_line_buffer.md
Name: isp_multi_line_buffer

Overview:
- Parametrised successor to the single dual-port RAM model: a circular multi-line buffer for ISP window filters (debayer, 3x3/5x5 kernels).
- Stores the last LINES-1 image lines in LINES-1 banks of simple dual-port RAM, one bank per line.
- Each accepted input pixel produces, one cycle later, a vertical column of LINES pixels: the current pixel plus the same column from each previous line.
- Sits between the pixel-stream front end and the window/kernel stages; runtime line width and frame restart are supported.

Parameters:
- DATA_WIDTH, 14, bits per pixel.
- ADDR_WIDTH, 11, column address width; maximum line length is 2**ADDR_WIDTH.
- LINES, 3, column height in lines; legal range 2..8; instantiates LINES-1 banks.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- frame_start_i  in  1  start-of-frame pulse; clears position and fill state, samples line_width_i.
- line_width_i  in  ADDR_WIDTH  active pixels per line; 0 means 2**ADDR_WIDTH.
- pixel_valid_i  in  1  input pixel strobe; no backpressure.
- pixel_data_i  in  DATA_WIDTH  input pixel.
- col_valid_o  out  1  column output valid.
- col_data_o  out  LINES*DATA_WIDTH  slice k, bits [k*DW +: DW], is the pixel k lines above the current one; slice 0 is the current pixel.
- col_x_o  out  ADDR_WIDTH  column index of the output.
- col_last_o  out  1  output is the last column of its line.
- rows_filled_o  out  3  previous lines available, saturating at LINES-1.

Behaviour:
- Reset values:
  - col_valid_o=0, col_data_o=0, col_x_o=0, col_last_o=0, rows_filled_o=0.
  - Internal x=0, bank pointer b=0, width register=0 (full width).
  - RAM contents are not cleared by reset; stale data is masked by the fill logic below.
- Latency: exactly 1 cycle from pixel_valid_i to col_valid_o. col_valid_o is high only in cycles after a valid input.
- Per valid pixel at column x with bank pointer b:
  - Write pixel_data_i into bank b at address x.
  - Read address x from all banks in the same cycle.
  - Slice k (1..LINES-1) is taken from bank (b-k) mod (LINES-1).
  - RAMs are read-first on a same-address collision, so slice LINES-1 (bank b) returns the old line before it is overwritten.
- Masking: slice k is driven 0 when k > rows_filled at the time of the read.
- Column wrap:
  - x increments on each valid pixel.
  - When x == width-1, the next x is 0, b advances modulo LINES-1, and rows_filled increments (saturating at LINES-1).
  - col_last_o=1 accompanies that pixel's output.
  - When width=0, wrap happens at 2**ADDR_WIDTH-1.
- Gaps: pixel_valid_i low holds all state; col_valid_o=0 in the following cycle, and col_data_o holds its last value.
- frame_start_i:
  - Synchronously clears x, b and rows_filled, and loads the width register from line_width_i.
  - If pixel_valid_i is high in the same cycle, that pixel is the first pixel of the new frame: written at x=0, bank 0, all slices except slice 0 masked to 0.
  - A frame_start_i mid-line abandons the partial line.
- rst_i mid-operation: outputs take their reset values in the next cycle, and the in-flight pixel is dropped.
- rst_i has priority over frame_start_i.
- line_width_i changes are ignored except when frame_start_i is high.
- RAM banks are inferred, one write port and one read port each; no other multi-port structures.

Test Plan:
- Continuous lines, LINES=3, width=4, pixels 1..12 over 3 lines:
  - Line 0 outputs (1,0,0)..(4,0,0).
  - Line 1 outputs (5,1,0)..(8,4,0).
  - Line 2 outputs (9,5,1)..(12,8,4).
  - col_last_o on the 4th column of each line; rows_filled_o goes 0, 1, 2.
- Bank rotation past fill, width=4, 5 lines of pixels 1..20:
  - Line 4 column 0 reads (17,13,9), confirming read-first overwrite and modulo bank selection.
  - rows_filled_o stays at 2.
- Gapped input, valid high every other cycle, width=4:
  - Outputs identical to the continuous case.
  - col_valid_o strictly follows pixel_valid_i by 1 cycle, and col_x_o counts 0..3 with no skips.
- frame_start_i with pixel_valid_i after 6 pixels, width=4:
  - The coincident pixel is output at col_x_o=0 with slices 1..2 = 0.
  - rows_filled_o=0; the new line_width_i=2 takes effect, with col_last_o at x=1.
- width=0 with ADDR_WIDTH=3:
  - Wrap occurs after 8 pixels, with col_last_o at x=7.
- rst_i asserted during line 1:
  - All outputs are 0 the next cycle.
  - After release plus frame_start_i, the first output has slices 1..2 = 0 despite stale RAM contents.
